// File: rtl/coin_pkg.sv
// coin_pkg: shared constants, coin codes, nickel values and FSM states for the coin controller
package coin_pkg;
    localparam int WIDTH      = 16;
    localparam int FRAC_BITS  = 11;
    localparam int COIN_WIDTH = 3;
    localparam int CNT_WIDTH  = 11;

    typedef enum logic [2:0] {
        COIN_NONE = 3'd0,
        NICKEL    = 3'd1,
        DIME      = 3'd2,
        QUARTER   = 3'd3,
        HALF      = 3'd4,
        DOLLAR    = 3'd5
    } coin_e;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;

    // Codes 0, 6 and 7 are worth nothing
    function automatic logic [4:0] coin_value(input logic [2:0] c);
        return c == DOLLAR  ? 5'd20 :
               c == HALF    ? 5'd10 :
               c == QUARTER ? 5'd5  :
               c == DIME    ? 5'd2  :
               c == NICKEL  ? 5'd1  : 5'd0;
    endfunction
endpackage

// File: rtl/change_coin_select.sv
// change_coin_select: greedy pick of the largest coin not exceeding the remaining change
module change_coin_select #(
    parameter int COIN_WIDTH = coin_pkg::COIN_WIDTH,
    parameter int CNT_WIDTH  = coin_pkg::CNT_WIDTH
) (
    input  logic [CNT_WIDTH-1:0]  remain,
    output logic [COIN_WIDTH-1:0] code,
    output logic [CNT_WIDTH-1:0]  value
);
    import coin_pkg::*;

    assign code = COIN_WIDTH'(remain >= CNT_WIDTH'(20) ? DOLLAR  :
                              remain >= CNT_WIDTH'(10) ? HALF    :
                              remain >= CNT_WIDTH'(5)  ? QUARTER :
                              remain >= CNT_WIDTH'(2)  ? DIME    :
                              remain >= CNT_WIDTH'(1)  ? NICKEL  : COIN_NONE);
    assign value = CNT_WIDTH'(coin_value(code));
endmodule

// File: rtl/coin_change_controller.sv
// coin_change_controller: takes a price, collects coins, dispenses once and returns greedy change
module coin_change_controller #(
    parameter int WIDTH      = coin_pkg::WIDTH,
    parameter int FRAC_BITS  = coin_pkg::FRAC_BITS,
    parameter int COIN_WIDTH = coin_pkg::COIN_WIDTH,
    parameter int CNT_WIDTH  = coin_pkg::CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      purchase_msg,
    input  logic                  purchase_val,
    output logic                  purchase_rdy,
    input  logic [COIN_WIDTH-1:0] coin_msg,
    input  logic                  coin_val,
    output logic                  coin_rdy,
    output logic                  dispense_msg,
    output logic                  dispense_val,
    input  logic                  dispense_rdy,
    output logic [COIN_WIDTH-1:0] change_msg,
    output logic                  change_val,
    input  logic                  change_rdy
);
    import coin_pkg::*;

    localparam int PW = WIDTH + 6;

    logic [1:0]            state;
    logic                  up;
    logic [CNT_WIDTH-1:0]  price_n, deposit_n, remain_n;
    logic [CNT_WIDTH-1:0]  price_nxt, deposit_nxt, pick_val;
    logic [COIN_WIDTH-1:0] pick_code;
    logic [PW-1:0]         price_wide;

    // Round the fixed-point dollar price to the nearest nickel
    assign price_wide  = PW'(purchase_msg) * PW'(20) + (PW'(1) << (FRAC_BITS - 1));
    assign price_nxt   = CNT_WIDTH'(price_wide >> FRAC_BITS);
    assign deposit_nxt = deposit_n + CNT_WIDTH'(coin_value(coin_msg));

    change_coin_select #(
        .COIN_WIDTH(COIN_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sel (
        .remain(remain_n),
        .code  (pick_code),
        .value (pick_val)
    );

    // up keeps purchase_rdy low until the first edge after reset release
    assign purchase_rdy = up && state == IDLE;
    assign coin_rdy     = state == COLLECT;
    assign dispense_val = state == DISPENSE;
    assign dispense_msg = dispense_val;
    assign change_val   = state == CHANGE;
    assign change_msg   = change_val ? pick_code : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            up        <= 1'b0;
            price_n   <= '0;
            deposit_n <= '0;
            remain_n  <= '0;
        end else begin
            up <= 1'b1;
            case (state)
                IDLE: if (purchase_val && purchase_rdy) begin
                    price_n   <= price_nxt;
                    deposit_n <= '0;
                    remain_n  <= '0;
                    state     <= price_nxt == '0 ? DISPENSE : COLLECT;
                end
                COLLECT: if (coin_val) begin
                    deposit_n <= deposit_nxt;
                    if (deposit_nxt >= price_n) begin
                        remain_n <= deposit_nxt - price_n;
                        state    <= DISPENSE;
                    end
                end
                DISPENSE: if (dispense_rdy) state <= remain_n != '0 ? CHANGE : IDLE;
                CHANGE: if (change_rdy) begin
                    remain_n <= remain_n - pick_val;
                    if (remain_n == pick_val) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coin_change_controller.sv
// tb_coin_change_controller: table-driven purchases plus backpressure and mid-operation reset sequences
module tb_coin_change_controller;
    logic        clock, resetn;
    logic [15:0] purchase_msg;
    logic        purchase_val, purchase_rdy;
    logic [2:0]  coin_msg;
    logic        coin_val, coin_rdy;
    logic        dispense_msg, dispense_val, dispense_rdy;
    logic [2:0]  change_msg;
    logic        change_val, change_rdy;
    int          checks = 0;
    int          errors = 0;

    coin_change_controller dut (
        .clock       (clock),
        .resetn      (resetn),
        .purchase_msg(purchase_msg),
        .purchase_val(purchase_val),
        .purchase_rdy(purchase_rdy),
        .coin_msg    (coin_msg),
        .coin_val    (coin_val),
        .coin_rdy    (coin_rdy),
        .dispense_msg(dispense_msg),
        .dispense_val(dispense_val),
        .dispense_rdy(dispense_rdy),
        .change_msg  (change_msg),
        .change_val  (change_val),
        .change_rdy  (change_rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0]     price;
        logic [2:0]      nc;
        logic [3:0][2:0] coins;
        logic [2:0]      nk;
        logic [3:0][2:0] chg;
    } vec_t;

    vec_t tab[7];

    function automatic vec_t mk(input logic [15:0] p, input logic [2:0] nc,
                                input logic [2:0] c0, input logic [2:0] c1,
                                input logic [2:0] c2, input logic [2:0] c3,
                                input logic [2:0] nk,
                                input logic [2:0] k0, input logic [2:0] k1,
                                input logic [2:0] k2, input logic [2:0] k3);
        vec_t v;
        v.price = p;
        v.nc    = nc;
        v.coins = {c3, c2, c1, c0};
        v.nk    = nk;
        v.chg   = {k3, k2, k1, k0};
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_price(input logic [15:0] m);
        int n = 0;
        purchase_msg = m;
        purchase_val = 1'b1;
        while (!purchase_rdy && n < 50) begin
            tick();
            n++;
        end
        check("purchase_rdy_wait", int'(purchase_rdy), 1);
        tick();
        purchase_val = 1'b0;
    endtask

    task automatic send_coin(input logic [2:0] c);
        int n = 0;
        coin_msg = c;
        coin_val = 1'b1;
        while (!coin_rdy && n < 50) begin
            tick();
            n++;
        end
        check("coin_rdy_wait", int'(coin_rdy), 1);
        tick();
        coin_val = 1'b0;
    endtask

    task automatic take_dispense();
        int n = 0;
        dispense_rdy = 1'b1;
        while (!dispense_val && n < 50) begin
            tick();
            n++;
        end
        check("dispense_val", int'(dispense_val), 1);
        check("dispense_msg", int'(dispense_msg), 1);
        tick();
        dispense_rdy = 1'b0;
    endtask

    task automatic take_change(input logic [2:0] code);
        int n = 0;
        change_rdy = 1'b1;
        while (!change_val && n < 50) begin
            tick();
            n++;
        end
        check("change_val", int'(change_val), 1);
        check("change_msg", int'(change_msg), int'(code));
        tick();
        change_rdy = 1'b0;
    endtask

    initial begin
        logic [2:0] stall_codes[4];
        logic       seen;
        resetn       = 1'b0;
        purchase_msg = '0;
        purchase_val = 1'b0;
        coin_msg     = '0;
        coin_val     = 1'b0;
        dispense_rdy = 1'b0;
        change_rdy   = 1'b0;

        // price msg, coins, expected change codes (nickels: price rounds to nearest)
        tab[0] = mk(16'd1024, 3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0);
        tab[1] = mk(16'd1331, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0);
        tab[2] = mk(16'd2048, 3'd2, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        tab[3] = mk(16'd102,  3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd3, 3'd2, 3'd2);
        tab[4] = mk(16'd204,  3'd4, 3'd0, 3'd7, 3'd6, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        tab[5] = mk(16'd0,    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        tab[6] = mk(16'd716,  3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0);

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", int'({purchase_rdy, coin_rdy, dispense_val, dispense_msg, change_val, change_msg}), 0);
        resetn = 1'b1;
        #1;
        check("rdy_before_edge", int'(purchase_rdy), 0);
        tick();
        check("rdy_after_reset", int'(purchase_rdy), 1);

        for (int i = 0; i < 7; i++) begin
            send_price(tab[i].price);
            if (tab[i].nc == 0) check("zero_price_dispense", int'(dispense_val), 1);
            for (int j = 0; j < int'(tab[i].nc); j++) begin
                send_coin(tab[i].coins[j]);
                check("dispense_after_coin", int'(dispense_val), j == int'(tab[i].nc) - 1 ? 1 : 0);
            end
            take_dispense();
            for (int k = 0; k < int'(tab[i].nk); k++) take_change(tab[i].chg[k]);
            check("back_to_idle", int'(purchase_rdy), 1);
            check("no_extra_change", int'(change_val), 0);
        end

        // Backpressure on change with activity on the other channels
        stall_codes = '{3'd4, 3'd3, 3'd2, 3'd2};
        send_price(16'd102);
        send_coin(3'd5);
        take_dispense();
        for (int k = 0; k < 4; k++) begin
            coin_val     = 1'b1;
            purchase_val = 1'b1;
            for (int s = 0; s < 5; s++) begin
                check("stall_val", int'(change_val), 1);
                check("stall_msg", int'(change_msg), int'(stall_codes[k]));
                check("stall_others", int'({purchase_rdy, coin_rdy, dispense_val}), 0);
                tick();
            end
            coin_val     = 1'b0;
            purchase_val = 1'b0;
            take_change(stall_codes[k]);
        end
        check("stall_idle", int'(purchase_rdy), 1);

        // Asynchronous reset mid-collection forfeits the deposit
        send_price(16'd4096);
        send_coin(3'd5);
        check("collect_before_reset", int'(coin_rdy), 1);
        @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({purchase_rdy, coin_rdy, dispense_val, dispense_msg, change_val, change_msg}), 0);
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;
        tick();
        check("rdy_after_mid_reset", int'(purchase_rdy), 1);
        dispense_rdy = 1'b1;
        change_rdy   = 1'b1;
        seen = 1'b0;
        for (int s = 0; s < 10; s++) begin
            seen = seen | dispense_val | change_val;
            tick();
        end
        check("no_output_after_reset", int'(seen), 0);
        dispense_rdy = 1'b0;
        change_rdy   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
